param_pipe_reg: RTL and testbench



---
 rtl/param_pipe_reg.sv | 81 ++++++++
 tb/tb_param_pipe_reg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_pipe_reg.sv
// DEPTH-stage valid/ready register pipeline with collapsing bubbles, flush and occupancy count.
// Latency DEPTH cycles; an empty stage accepts data even while the output is stalled.
module param_pipe_reg #(
  parameter int              WIDTH   = 8,
  parameter int              DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int             CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] stage_rdy;
  logic             in_fire;

  // A stage may load when it or any stage downstream of it has a hole, or the output drains.
  always_comb begin
    stage_rdy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      stage_rdy[i] = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        if (!valid_q[j]) stage_rdy[i] = 1'b1;
      end
    end
  end

  assign in_ready = stage_rdy[0] & ~flush & ~rst;
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = '0;
    if (flush) begin
      valid_d = '0;
    end else begin
      if (stage_rdy[0]) begin
        valid_d[0] = in_fire;
        if (in_fire) data_d[0] = in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (stage_rdy[i]) begin
          valid_d[i] = valid_q[i-1];
          if (valid_q[i-1]) data_d[i] = data_q[i-1];
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= RST_VAL;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_param_pipe_reg.sv
// Bench for param_pipe_reg: queue-based word/position model checked every cycle, plus directed literal checks.
module tb_param_pipe_reg;

  localparam int         WIDTH   = 8;
  localparam int         DEPTH   = 3;
  localparam logic [7:0] RST_VAL = 8'hA5;
  localparam int         CW      = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = 8'h00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  logic [7:0] md[$];
  int         mp[$];
  logic [7:0] got[$];
  logic [7:0] expq[$];

  param_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RST_VAL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_in_ready();
    return !rst && !flush && (md.size() < DEPTH || out_ready);
  endfunction

  function automatic bit m_out_valid();
    return md.size() > 0 && mp[0] == DEPTH - 1;
  endfunction

  // Model: words kept in order with their stage position; each edge every word moves one
  // stage toward the output unless the word ahead blocks it.
  always @(posedge clk) begin
    bit hs_in, hs_out;
    int lim, np;
    hs_in  = in_valid && m_in_ready();
    hs_out = m_out_valid() && out_ready;
    if (rst) begin
      started = 1'b1;
      md.delete();
      mp.delete();
    end else begin
      if (hs_out) begin
        void'(md.pop_front());
        void'(mp.pop_front());
      end
      if (flush) begin
        md.delete();
        mp.delete();
      end else begin
        lim = DEPTH - 1;
        for (int i = 0; i < mp.size(); i++) begin
          np = mp[i] + 1;
          if (np > lim) np = lim;
          mp[i] = np;
          lim = np - 1;
        end
        if (hs_in) begin
          md.push_back(in_data);
          mp.push_back(0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cmp_count", 32'(count), 32'(md.size()));
      chk("cmp_out_valid", 32'(out_valid), 32'(m_out_valid()));
      chk("cmp_in_ready", 32'(in_ready), 32'(m_in_ready()));
      if (m_out_valid()) chk("cmp_out_data", 32'(out_data), 32'(md[0]));
      if (!rst && out_valid && out_ready) got.push_back(out_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_seq(input string nm);
    chk({nm, "_len"}, 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (i < got.size()) chk({nm, "_word"}, 32'(got[i]), 32'(expq[i]));
    end
    got.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two edges
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'hA5);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Streaming at full rate
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(k + 1);
      step();
      if (k == 2) begin
        chk("stream_first_valid", 32'(out_valid), 32'h1);
        chk("stream_first_data", 32'(out_data), 32'h01);
        chk("stream_full_count", 32'(count), 32'h3);
      end
    end
    in_valid = 1'b0;
    repeat (4) step();
    expq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    chk_seq("stream_seq");

    // Backpressure with a bubble that collapses
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h10; step();
    in_valid = 1'b0; step();
    in_valid = 1'b1; in_data = 8'h11; step();
    in_valid = 1'b1; in_data = 8'h12; step();
    in_valid = 1'b0;
    #1;
    chk("bp_count", 32'(count), 32'h3);
    chk("bp_in_ready", 32'(in_ready), 32'h0);
    chk("bp_out_data", 32'(out_data), 32'h10);
    in_valid = 1'b1; in_data = 8'h77;
    step();
    step();
    chk("bp_hold_data", 32'(out_data), 32'h10);
    chk("bp_hold_valid", 32'(out_valid), 32'h1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    expq = '{8'h10, 8'h11, 8'h12};
    chk_seq("bp_seq");

    // Full pipe: pop and push in the same cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h1A; step();
    in_data = 8'h1B; step();
    in_data = 8'h1C; step();
    in_data = 8'h20; out_ready = 1'b1;
    #1;
    chk("full_in_ready", 32'(in_ready), 32'h1);
    step();
    chk("full_count_stays", 32'(count), 32'h3);
    in_valid = 1'b0;
    repeat (4) step();
    expq = '{8'h1A, 8'h1B, 8'h1C, 8'h20};
    chk_seq("full_seq");

    // Flush drops everything and blocks the concurrent push
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h31; step();
    in_data = 8'h32; step();
    in_data = 8'h33; step();
    flush = 1'b1; in_data = 8'h30;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'h0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    out_ready = 1'b1;
    repeat (5) step();
    expq.delete();
    chk_seq("flush_seq");

    // Reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h40; step();
    in_data = 8'h41; step();
    in_valid = 1'b0;
    chk("mid_count_before", 32'(count), 32'h2);
    rst = 1'b1;
    step();
    chk("mid_rst_count", 32'(count), 32'h0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_out_data", 32'(out_data), 32'hA5);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    expq.delete();
    chk_seq("mid_rst_seq");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
